// File: rtl/uart_pkg.sv
// Shared constants for the UART receiver: FSM state encoding, oversampling
// ratio and the mid-bit sample point, plus an even-parity helper.
package uart_pkg;

   typedef logic [2:0] rx_state_t;

   localparam int OVERSAMPLE = 16;
   localparam int MID_SAMPLE = 7;

   localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);
   localparam logic [3:0] TICK_MID  = 4'(MID_SAMPLE);

   localparam rx_state_t ST_IDLE   = 3'd0;
   localparam rx_state_t ST_START  = 3'd1;
   localparam rx_state_t ST_DATA   = 3'd2;
   localparam rx_state_t ST_PARITY = 3'd3;
   localparam rx_state_t ST_STOP   = 3'd4;

   // Value the parity bit must take so data plus parity has an even number of ones.
   function automatic logic even_parity(input logic [7:0] data);
      return ^data;
   endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Free-running oversample tick generator: one-cycle tick every DIV sysclk
// cycles, counter wraps from DIV-1 back to 0.
module baud_tick_gen #(
   parameter int DIV = 10
) (
   input  logic sysclk,
   input  logic reset,
   output logic tick
);

   localparam int DIV_SAFE = (DIV < 1) ? 1 : DIV;
   localparam int CW       = (DIV_SAFE > 1) ? $clog2(DIV_SAFE) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DIV_SAFE - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_ZERO = CW'(0);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   logic          tick_q;
   logic          tick_d;

   // Next divider count and tick strobe.
   always_comb begin
      if (cnt_q == CNT_LAST) begin
         cnt_d  = CNT_ZERO;
         tick_d = 1'b1;
      end else begin
         cnt_d  = cnt_q + CNT_ONE;
         tick_d = 1'b0;
      end
   end

   // Divider and tick registers.
   always_ff @(posedge sysclk) begin
      if (!reset) begin
         cnt_q  <= CNT_ZERO;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= tick_d;
      end
   end

   assign tick = tick_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver (16x oversampled, 8N1) feeding a show-ahead byte FIFO.
// Define UART_PARITY_EN to expect an even-parity bit between data and stop.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int CLK_FREQ   = 100000000,
   parameter int BAUD       = 9600,
   parameter int FIFO_DEPTH = 4
) (
   input  logic       sysclk,
   input  logic       reset,
   input  logic       UART_RX,
   input  logic       rx_rd,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_overrun,
   output logic       frame_err,
   output logic       parity_err
);

   localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
   localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW  = AW + 1;

   localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);
   localparam logic [CW-1:0] CNT_ZERO = CW'(0);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [AW-1:0] PTR_ZERO = AW'(0);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

`ifdef UART_PARITY_EN
   localparam rx_state_t ST_AFTER_DATA = ST_PARITY;
`else
   localparam rx_state_t ST_AFTER_DATA = ST_STOP;
`endif

   logic            tick;
   logic            rx_s;

   logic [1:0]      sync_q,       sync_d;
   rx_state_t       state_q,      state_d;
   logic [3:0]      tick_cnt_q,   tick_cnt_d;
   logic [2:0]      bit_cnt_q,    bit_cnt_d;
   logic [7:0]      shift_q,      shift_d;
   logic            armed_q,      armed_d;
   logic            par_bad_q,    par_bad_d;
   logic            push_q,       push_d;
   logic            frame_err_q,  frame_err_d;
   logic            parity_err_q, parity_err_d;

   logic [7:0]      mem_q [FIFO_DEPTH];
   logic [7:0]      mem_d [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr_q,     wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q,     rd_ptr_d;
   logic [CW-1:0]   count_q,      count_d;
   logic            ovr_q,        ovr_d;
   logic [7:0]      rx_data_q,    rx_data_d;
   logic            rx_valid_q,   rx_valid_d;

   logic            do_pop;
   logic            do_push;
   logic            fifo_full;
   logic            ovr_set;

   baud_tick_gen #(
      .DIV (DIV)
   ) u_tick (
      .sysclk (sysclk),
      .reset  (reset),
      .tick   (tick)
   );

   assign rx_s = sync_q[1];

   // Two-flop synchronizer shift for the serial line.
   always_comb begin
      sync_d = {sync_q[0], UART_RX};
   end

   // Receive FSM: start qualification, data/parity/stop sampling and error pulses.
   always_comb begin
      state_d      = state_q;
      tick_cnt_d   = tick_cnt_q;
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      armed_d      = armed_q;
      par_bad_d    = par_bad_q;
      push_d       = 1'b0;
      frame_err_d  = 1'b0;
      parity_err_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // After a framing error the line must be seen high before a new start counts.
            if (!armed_q) begin
               armed_d = rx_s;
            end else if (!rx_s) begin
               state_d    = ST_START;
               tick_cnt_d = 4'd0;
               bit_cnt_d  = 3'd0;
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_START: begin
            if (!tick) begin
               state_d = ST_START;
            end else if (tick_cnt_q == TICK_MID) begin
               if (!rx_s) begin
                  state_d    = ST_DATA;
                  tick_cnt_d = 4'd0;
                  par_bad_d  = 1'b0;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               tick_cnt_d = tick_cnt_q + 4'd1;
            end
         end

         ST_DATA: begin
            if (!tick) begin
               state_d = ST_DATA;
            end else if (tick_cnt_q == TICK_LAST) begin
               shift_d    = {rx_s, shift_q[7:1]};
               tick_cnt_d = 4'd0;
               bit_cnt_d  = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  state_d = ST_AFTER_DATA;
               end else begin
                  state_d = ST_DATA;
               end
            end else begin
               tick_cnt_d = tick_cnt_q + 4'd1;
            end
         end

`ifdef UART_PARITY_EN
         ST_PARITY: begin
            if (!tick) begin
               state_d = ST_PARITY;
            end else if (tick_cnt_q == TICK_LAST) begin
               tick_cnt_d = 4'd0;
               state_d    = ST_STOP;
               if (even_parity(shift_q) != rx_s) begin
                  par_bad_d    = 1'b1;
                  parity_err_d = 1'b1;
               end else begin
                  par_bad_d = 1'b0;
               end
            end else begin
               tick_cnt_d = tick_cnt_q + 4'd1;
            end
         end
`endif

         ST_STOP: begin
            if (!tick) begin
               state_d = ST_STOP;
            end else if (tick_cnt_q == TICK_LAST) begin
               state_d    = ST_IDLE;
               tick_cnt_d = 4'd0;
               if (rx_s) begin
                  push_d  = !par_bad_q;
                  armed_d = 1'b1;
               end else begin
                  frame_err_d = 1'b1;
                  armed_d     = 1'b0;
               end
            end else begin
               tick_cnt_d = tick_cnt_q + 4'd1;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // FIFO bookkeeping; a full FIFO still accepts a push when a pop frees a slot that cycle.
   always_comb begin
      mem_d     = mem_q;
      do_pop    = rx_rd && (count_q != CNT_ZERO);
      fifo_full = (count_q == CNT_FULL);
      do_push   = push_q && (!fifo_full || do_pop);
      ovr_set   = push_q && fifo_full && !do_pop;

      if (do_push) begin
         mem_d[wr_ptr_q] = shift_q;
         wr_ptr_d        = wr_ptr_q + PTR_ONE;
      end else begin
         wr_ptr_d = wr_ptr_q;
      end

      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
         rd_ptr_d = rd_ptr_q;
      end

      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase

      if (ovr_set) begin
         ovr_d = 1'b1;
      end else if (do_pop) begin
         ovr_d = 1'b0;
      end else begin
         ovr_d = ovr_q;
      end

      // Outputs are registered from the next-state head so the show-ahead byte has no extra lag.
      if (count_d != CNT_ZERO) begin
         rx_data_d  = mem_d[rd_ptr_d];
         rx_valid_d = 1'b1;
      end else begin
         rx_data_d  = 8'h00;
         rx_valid_d = 1'b0;
      end
   end

   // Synchronizer and receive FSM registers.
   always_ff @(posedge sysclk) begin
      if (!reset) begin
         sync_q       <= 2'b11;
         state_q      <= ST_IDLE;
         tick_cnt_q   <= 4'd0;
         bit_cnt_q    <= 3'd0;
         shift_q      <= 8'h00;
         armed_q      <= 1'b0;
         par_bad_q    <= 1'b0;
         push_q       <= 1'b0;
         frame_err_q  <= 1'b0;
         parity_err_q <= 1'b0;
      end else begin
         sync_q       <= sync_d;
         state_q      <= state_d;
         tick_cnt_q   <= tick_cnt_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         armed_q      <= armed_d;
         par_bad_q    <= par_bad_d;
         push_q       <= push_d;
         frame_err_q  <= frame_err_d;
         parity_err_q <= parity_err_d;
      end
   end

   // FIFO storage, pointers, overrun flag and registered consumer outputs.
   always_ff @(posedge sysclk) begin
      if (!reset) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= 8'h00;
         end
         wr_ptr_q   <= PTR_ZERO;
         rd_ptr_q   <= PTR_ZERO;
         count_q    <= CNT_ZERO;
         ovr_q      <= 1'b0;
         rx_data_q  <= 8'h00;
         rx_valid_q <= 1'b0;
      end else begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         ovr_q      <= ovr_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
      end
   end

   assign rx_data    = rx_data_q;
   assign rx_valid   = rx_valid_q;
   assign rx_overrun = ovr_q;
   assign frame_err  = frame_err_q;
   assign parity_err = parity_err_q;

endmodule
